// File: rtl/async_resp_queue.sv
// async_resp_queue: FIFO-backed responder endpoint for the req/ack dataflow protocol.
// Define ASYNC_RESP_QUEUE_STATS_EN to add the stat_sent/stat_starve/stat_drop counters.
module async_resp_queue #(
  parameter int data_width  = 32,
  parameter int depth       = 4,
  parameter int output_size = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [data_width-1:0]  wr_data,
  output logic                   wr_full,
  input  logic [output_size-1:0] req,
  output logic                   ack,
  output logic [data_width-1:0]  dout,
  output logic [$clog2(depth):0] level
`ifdef ASYNC_RESP_QUEUE_STATS_EN
  ,
  output logic [31:0]            stat_sent,
  output logic [31:0]            stat_starve,
  output logic [31:0]            stat_drop
`endif
);

  localparam int AW = $clog2(depth);
  localparam int LW = AW + 1;

  logic [data_width-1:0] mem_r [depth];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  empty_s;
  logic [LW-1:0]         level_nxt_s;

  // Push/pop decisions and next occupancy, all from pre-edge state.
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    empty_s     = 1'b0;
    level_nxt_s = level;
    empty_s     = (level == {LW{1'b0}});
    push_s      = wr_en & ~wr_full;
    // ack high means the requesters still show the previous req; skip one edge.
    pop_s       = (&req) & ~ack & ~empty_s;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level + LW'(1);
      2'b01:   level_nxt_s = level - LW'(1);
      default: level_nxt_s = level;
    endcase
  end

  // Word storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, and the registered ack/dout delivery outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level    <= {LW{1'b0}};
      wr_full  <= 1'b0;
      ack      <= 1'b0;
      dout     <= {data_width{1'b0}};
    end else begin
      ack     <= pop_s;
      level   <= level_nxt_s;
      wr_full <= (level_nxt_s == LW'(depth));
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        dout     <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

`ifdef ASYNC_RESP_QUEUE_STATS_EN
  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_sent   <= 32'd0;
      stat_starve <= 32'd0;
      stat_drop   <= 32'd0;
    end else begin
      if (pop_s) begin
        stat_sent <= stat_sent + 32'd1;
      end
      if ((&req) & ~ack & empty_s) begin
        stat_starve <= stat_starve + 32'd1;
      end
      if (wr_en & wr_full) begin
        stat_drop <= stat_drop + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_async_resp_queue.sv
// Self-checking bench for async_resp_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_async_resp_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NREQ  = 2;

  logic            clk;
  logic            rst;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic            wr_full;
  logic [NREQ-1:0] req;
  logic            ack;
  logic [DW-1:0]   dout;
  logic [2:0]      level;
`ifdef ASYNC_RESP_QUEUE_STATS_EN
  logic [31:0]     stat_sent;
  logic [31:0]     stat_starve;
  logic [31:0]     stat_drop;
`endif

  async_resp_queue #(
    .data_width (DW),
    .depth      (DEPTH),
    .output_size(NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_full    (wr_full),
    .req        (req),
    .ack        (ack),
    .dout       (dout),
    .level      (level)
`ifdef ASYNC_RESP_QUEUE_STATS_EN
    ,
    .stat_sent  (stat_sent),
    .stat_starve(stat_starve),
    .stat_drop  (stat_drop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] model_q [$];
  logic          m_ack;
  logic [DW-1:0] m_dout;
  logic [31:0]   m_sent, m_starve, m_drop;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance model by the protocol rules, compare everything.
  task automatic cycle(input logic r, input logic we, input logic [DW-1:0] wd, input logic [NREQ-1:0] rq);
    logic full_m, deliver_m, starve_m, drop_m;
    rst = r; wr_en = we; wr_data = wd; req = rq;
    full_m    = (model_q.size() == DEPTH);
    deliver_m = (&rq) && !m_ack && (model_q.size() != 0);
    starve_m  = (&rq) && !m_ack && (model_q.size() == 0);
    drop_m    = we && full_m;
    @(posedge clk);
    #1;
    if (r) begin
      model_q.delete();
      m_ack = 1'b0; m_dout = '0;
      m_sent = '0; m_starve = '0; m_drop = '0;
    end else begin
      m_ack = deliver_m;
      if (deliver_m) begin
        m_dout = model_q.pop_front();
        m_sent = m_sent + 32'd1;
      end
      if (we && !full_m) model_q.push_back(wd);
      if (starve_m) m_starve = m_starve + 32'd1;
      if (drop_m) m_drop = m_drop + 32'd1;
    end
    check_value("ack", ack, m_ack);
    check_value("dout", dout, m_dout);
    check_value("level", level, model_q.size());
    check_value("wr_full", wr_full, model_q.size() == DEPTH);
`ifdef ASYNC_RESP_QUEUE_STATS_EN
    check_value("stat_sent", stat_sent, m_sent);
    check_value("stat_starve", stat_starve, m_starve);
    check_value("stat_drop", stat_drop, m_drop);
`endif
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; req = '0;
    m_ack = 1'b0; m_dout = '0; m_sent = '0; m_starve = '0; m_drop = '0;

    cycle(1'b1, 1'b0, 32'h0, 2'b00);
    cycle(1'b1, 1'b0, 32'h0, 2'b11);

    // Idle with requests held: nothing delivered
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 2'b11);
      check_value("idle_ack", ack, 1'b0);
    end
    check_value("idle_dout", dout, 32'h0);
    check_value("idle_level", level, 3'd0);

    // Single word
    cycle(1'b0, 1'b1, 32'h0000_00AA, 2'b11);
    check_value("single_noack", ack, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 2'b11);
    check_value("single_ack", ack, 1'b1);
    check_value("single_dout", dout, 32'h0000_00AA);
    check_value("single_level", level, 3'd0);
    cycle(1'b0, 1'b0, 32'h0, 2'b11);
    check_value("single_ack_drop", ack, 1'b0);

    // Ordering and two-cycle spacing
    for (int k = 0; k < 8; k++) begin
      if (k < 4) cycle(1'b0, 1'b1, DW'(k + 1), 2'b11);
      else       cycle(1'b0, 1'b0, 32'h0, 2'b11);
      check_value("order_ack", ack, (k % 2) == 1);
      if ((k % 2) == 1) check_value("order_dout", dout, DW'((k + 1) / 2));
    end
    cycle(1'b0, 1'b0, 32'h0, 2'b00);

    // Full: fifth push dropped
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, DW'(16 + k), 2'b00);
      if (k == 3) check_value("full_after4", wr_full, 1'b1);
    end
    check_value("full_level", level, 3'd4);
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 2'b11);
      check_value("drain_ack", ack, ((k % 2) == 0) && (k < 8));
      if (((k % 2) == 0) && (k < 8)) check_value("drain_dout", dout, DW'(16 + k / 2));
    end
    check_value("drain_level", level, 3'd0);
    cycle(1'b0, 1'b0, 32'h0, 2'b00);

    // Partial requests never consume
    cycle(1'b0, 1'b1, 32'h0000_0055, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 2'b01);
      check_value("partial_ack", ack, 1'b0);
      check_value("partial_level", level, 3'd1);
    end
    cycle(1'b0, 1'b0, 32'h0, 2'b11);
    check_value("multi_ack", ack, 1'b1);
    check_value("multi_dout", dout, 32'h0000_0055);
    check_value("multi_level", level, 3'd0);
    cycle(1'b0, 1'b0, 32'h0, 2'b11);
    check_value("multi_once", ack, 1'b0);

    // Reset on the edge where ack would fire
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DW'(32'h100 + i), 2'b00);
    cycle(1'b1, 1'b0, 32'h0, 2'b11);
    check_value("rst_ack", ack, 1'b0);
    check_value("rst_level", level, 3'd0);
    cycle(1'b0, 1'b1, 32'h7, 2'b11);
    cycle(1'b0, 1'b0, 32'h0, 2'b11);
    check_value("rst_next_ack", ack, 1'b1);
    check_value("rst_next_dout", dout, 32'h7);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0), $urandom,
            NREQ'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
